// File: rtl/mm2s_pkg.sv
// Shared definitions for the MM2S read engine: command layout, status layout,
// FSM encoding and AXI response codes.
package mm2s_pkg;

    localparam int CMD_W          = 72;
    localparam int CMD_BTT_LSB    = 0;
    localparam int CMD_BTT_W      = 23;
    localparam int CMD_EOF_BIT    = 30;
    localparam int CMD_SADDR_LSB  = 32;
    localparam int CMD_SADDR_W    = 32;
    localparam int CMD_TAG_LSB    = 64;
    localparam int CMD_TAG_W      = 4;

    localparam int STS_INTERR_BIT = 4;
    localparam int STS_DECERR_BIT = 5;
    localparam int STS_SLVERR_BIT = 6;
    localparam int STS_OKAY_BIT   = 7;

    localparam int REM_W          = 20;
    localparam int BURST_W        = 5;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_STS  = 2'd3
    } state_t;

    function automatic logic [7:0] pack_status(input logic [3:0] tag,
                                               input logic interr,
                                               input logic decerr,
                                               input logic slverr);
        logic [7:0] s;
        s = 8'h00;
        s[3:0]           = tag;
        s[STS_INTERR_BIT] = interr;
        s[STS_DECERR_BIT] = decerr;
        s[STS_SLVERR_BIT] = slverr;
        s[STS_OKAY_BIT]   = ~(interr | decerr | slverr);
        return s;
    endfunction

endpackage

// File: rtl/mm2s_burst_calc.sv
// Burst sizing: largest burst that fits the remaining beats, the burst cap
// and the distance to the next 4 KB boundary.
module mm2s_burst_calc
    import mm2s_pkg::*;
#(
    parameter int C_MAX_BURST = 16
) (
    input  logic [REM_W-1:0]   remaining,
    input  logic [11:0]        addr_low,
    output logic [BURST_W-1:0] burst_beats
);

    logic [12:0] page_bytes;
    logic [9:0]  page_beats;

    always_comb begin
        page_bytes  = 13'd4096 - {1'b0, addr_low};
        page_beats  = page_bytes[12:3];
        burst_beats = BURST_W'(C_MAX_BURST);
        if (remaining < REM_W'(C_MAX_BURST)) begin
            burst_beats = remaining[BURST_W-1:0];
        end
        // addr_low is beat-aligned, so page_beats is always at least 1
        if (10'(burst_beats) > page_beats) begin
            burst_beats = page_beats[BURST_W-1:0];
        end
    end

endmodule

// File: rtl/mm2s_read_engine.sv
// MM2S read engine: runs one datamover command at a time, reading memory over
// AXI4 in 4 KB-safe bursts and streaming the data out, then reports status.
module mm2s_read_engine
    import mm2s_pkg::*;
#(
    parameter int         C_M_AXI_ADDR_WIDTH = 32,
    parameter int         C_M_AXI_DATA_WIDTH = 64,
    parameter int         C_MAX_BURST        = 16,
    parameter logic [3:0] C_ARCACHE          = 4'b0011,
    parameter logic [2:0] C_PROT             = 3'b010
) (
    input  logic                          clk,
    input  logic                          rst,

    input  logic                          S_AXIS_CMD_TVALID,
    output logic                          S_AXIS_CMD_TREADY,
    input  logic [CMD_W-1:0]              S_AXIS_CMD_TDATA,

    output logic                          M_AXIS_STS_TVALID,
    input  logic                          M_AXIS_STS_TREADY,
    output logic [7:0]                    M_AXIS_STS_TDATA,

    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic [7:0]                    M_AXI_ARLEN,
    output logic [2:0]                    M_AXI_ARSIZE,
    output logic [1:0]                    M_AXI_ARBURST,
    output logic [3:0]                    M_AXI_ARCACHE,
    output logic [2:0]                    M_AXI_ARPROT,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,

    input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RLAST,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY,

    output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic [7:0]                    M_AXIS_TKEEP,
    output logic                          M_AXIS_TLAST,
    output logic                          M_AXIS_TVALID,
    input  logic                          M_AXIS_TREADY,

    output logic                          busy
);

    state_t                          state;
    logic [REM_W-1:0]                remaining;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   addr;
    logic [CMD_TAG_W-1:0]            tag;
    logic                            eof;
    logic                            interr;
    logic                            decerr;
    logic                            slverr;
    logic [BURST_W-1:0]              burst_q;
    logic [BURST_W-1:0]              beat_cnt;
    logic                            cmd_ready_r;
    logic                            arvalid_r;
    logic                            sts_valid_r;

    logic [BURST_W-1:0]              burst_beats;
    logic [CMD_BTT_W-1:0]            cmd_btt;
    logic [CMD_SADDR_W-1:0]          cmd_saddr;
    logic [CMD_TAG_W-1:0]            cmd_tag;
    logic                            cmd_eof;
    logic                            cmd_bad;
    logic                            data_st;
    logic                            r_hs;
    logic                            last_beat;
    logic                            final_burst;
    logic                            unused_cmd_bits;

    assign cmd_btt   = S_AXIS_CMD_TDATA[CMD_BTT_LSB +: CMD_BTT_W];
    assign cmd_saddr = S_AXIS_CMD_TDATA[CMD_SADDR_LSB +: CMD_SADDR_W];
    assign cmd_tag   = S_AXIS_CMD_TDATA[CMD_TAG_LSB +: CMD_TAG_W];
    assign cmd_eof   = S_AXIS_CMD_TDATA[CMD_EOF_BIT];
    assign cmd_bad   = (cmd_btt == '0) || (cmd_btt[2:0] != 3'd0) || (cmd_saddr[2:0] != 3'd0);
    assign unused_cmd_bits = &{1'b0, S_AXIS_CMD_TDATA[71:68], S_AXIS_CMD_TDATA[31],
                                S_AXIS_CMD_TDATA[29:23]};

    mm2s_burst_calc #(
        .C_MAX_BURST (C_MAX_BURST)
    ) u_burst_calc (
        .remaining   (remaining),
        .addr_low    (addr[11:0]),
        .burst_beats (burst_beats)
    );

    // Read data is a combinational pass-through; only the beat bookkeeping is registered.
    assign data_st     = (state == ST_DATA);
    assign r_hs        = data_st && M_AXI_RVALID && M_AXIS_TREADY;
    assign last_beat   = (beat_cnt == burst_q - BURST_W'(1));
    assign final_burst = (remaining == REM_W'(burst_q));

    assign M_AXIS_TVALID = data_st && M_AXI_RVALID;
    assign M_AXI_RREADY  = data_st && M_AXIS_TREADY;
    assign M_AXIS_TDATA  = M_AXI_RDATA;
    assign M_AXIS_TKEEP  = 8'hff;
    assign M_AXIS_TLAST  = data_st && eof && last_beat && final_burst;

    assign M_AXI_ARADDR  = addr;
    assign M_AXI_ARLEN   = {3'b000, burst_beats - BURST_W'(1)};
    assign M_AXI_ARSIZE  = 3'b011;
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARCACHE = C_ARCACHE;
    assign M_AXI_ARPROT  = C_PROT;
    assign M_AXI_ARVALID = arvalid_r;

    assign S_AXIS_CMD_TREADY = cmd_ready_r;
    assign M_AXIS_STS_TVALID = sts_valid_r;
    assign M_AXIS_STS_TDATA  = pack_status(tag, interr, decerr, slverr);
    assign busy              = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            remaining   <= '0;
            addr        <= '0;
            tag         <= '0;
            eof         <= 1'b0;
            interr      <= 1'b0;
            decerr      <= 1'b0;
            slverr      <= 1'b0;
            burst_q     <= '0;
            beat_cnt    <= '0;
            cmd_ready_r <= 1'b0;
            arvalid_r   <= 1'b0;
            sts_valid_r <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cmd_ready_r <= 1'b1;
                    if (S_AXIS_CMD_TVALID && cmd_ready_r) begin
                        cmd_ready_r <= 1'b0;
                        tag         <= cmd_tag;
                        eof         <= cmd_eof;
                        decerr      <= 1'b0;
                        slverr      <= 1'b0;
                        addr        <= C_M_AXI_ADDR_WIDTH'(cmd_saddr);
                        remaining   <= cmd_btt[CMD_BTT_W-1:3];
                        if (cmd_bad) begin
                            interr      <= 1'b1;
                            sts_valid_r <= 1'b1;
                            state       <= ST_STS;
                        end else begin
                            interr      <= 1'b0;
                            arvalid_r   <= 1'b1;
                            state       <= ST_ADDR;
                        end
                    end
                end
                ST_ADDR: begin
                    if (M_AXI_ARREADY) begin
                        arvalid_r <= 1'b0;
                        burst_q   <= burst_beats;
                        beat_cnt  <= '0;
                        state     <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (r_hs) begin
                        // The local beat count decides burst end; RLAST is only checked against it
                        if (M_AXI_RLAST != last_beat) begin
                            interr <= 1'b1;
                        end
                        if (M_AXI_RRESP == RESP_SLVERR) begin
                            slverr <= 1'b1;
                        end
                        if (M_AXI_RRESP == RESP_DECERR) begin
                            decerr <= 1'b1;
                        end
                        if (last_beat) begin
                            addr      <= addr + C_M_AXI_ADDR_WIDTH'({burst_q, 3'b000});
                            remaining <= remaining - REM_W'(burst_q);
                            if (final_burst) begin
                                sts_valid_r <= 1'b1;
                                state       <= ST_STS;
                            end else begin
                                arvalid_r   <= 1'b1;
                                state       <= ST_ADDR;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + BURST_W'(1);
                        end
                    end
                end
                ST_STS: begin
                    if (M_AXIS_STS_TREADY) begin
                        sts_valid_r <= 1'b0;
                        cmd_ready_r <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mm2s_read_engine.sv
// Bench for mm2s_read_engine: AXI read slave model, stream/status scoreboard
// and a directed command sequence including a mid-transfer reset.
module tb_mm2s_read_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        S_AXIS_CMD_TVALID = 1'b0;
    logic        S_AXIS_CMD_TREADY;
    logic [71:0] S_AXIS_CMD_TDATA = '0;
    logic        M_AXIS_STS_TVALID;
    logic        M_AXIS_STS_TREADY = 1'b1;
    logic [7:0]  M_AXIS_STS_TDATA;
    logic [31:0] M_AXI_ARADDR;
    logic [7:0]  M_AXI_ARLEN;
    logic [2:0]  M_AXI_ARSIZE;
    logic [1:0]  M_AXI_ARBURST;
    logic [3:0]  M_AXI_ARCACHE;
    logic [2:0]  M_AXI_ARPROT;
    logic        M_AXI_ARVALID;
    logic        M_AXI_ARREADY = 1'b0;
    logic [63:0] M_AXI_RDATA = '0;
    logic [1:0]  M_AXI_RRESP = 2'b00;
    logic        M_AXI_RLAST = 1'b0;
    logic        M_AXI_RVALID = 1'b0;
    logic        M_AXI_RREADY;
    logic [63:0] M_AXIS_TDATA;
    logic [7:0]  M_AXIS_TKEEP;
    logic        M_AXIS_TLAST;
    logic        M_AXIS_TVALID;
    logic        M_AXIS_TREADY = 1'b1;
    logic        busy;

    mm2s_read_engine dut (
        .clk               (clk),
        .rst               (rst),
        .S_AXIS_CMD_TVALID (S_AXIS_CMD_TVALID),
        .S_AXIS_CMD_TREADY (S_AXIS_CMD_TREADY),
        .S_AXIS_CMD_TDATA  (S_AXIS_CMD_TDATA),
        .M_AXIS_STS_TVALID (M_AXIS_STS_TVALID),
        .M_AXIS_STS_TREADY (M_AXIS_STS_TREADY),
        .M_AXIS_STS_TDATA  (M_AXIS_STS_TDATA),
        .M_AXI_ARADDR      (M_AXI_ARADDR),
        .M_AXI_ARLEN       (M_AXI_ARLEN),
        .M_AXI_ARSIZE      (M_AXI_ARSIZE),
        .M_AXI_ARBURST     (M_AXI_ARBURST),
        .M_AXI_ARCACHE     (M_AXI_ARCACHE),
        .M_AXI_ARPROT      (M_AXI_ARPROT),
        .M_AXI_ARVALID     (M_AXI_ARVALID),
        .M_AXI_ARREADY     (M_AXI_ARREADY),
        .M_AXI_RDATA       (M_AXI_RDATA),
        .M_AXI_RRESP       (M_AXI_RRESP),
        .M_AXI_RLAST       (M_AXI_RLAST),
        .M_AXI_RVALID      (M_AXI_RVALID),
        .M_AXI_RREADY      (M_AXI_RREADY),
        .M_AXIS_TDATA      (M_AXIS_TDATA),
        .M_AXIS_TKEEP      (M_AXIS_TKEEP),
        .M_AXIS_TLAST      (M_AXIS_TLAST),
        .M_AXIS_TVALID     (M_AXIS_TVALID),
        .M_AXIS_TREADY     (M_AXIS_TREADY),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [64:0] exp_beats[$];
    logic [7:0]  exp_sts[$];
    logic [39:0] exp_ar[$];
    logic [39:0] slv_ar[$];

    logic [31:0] err_addr   = 32'hFFFF_FFFF;
    logic [1:0]  err_resp   = 2'b00;
    bit          rand_tready = 1'b0;
    int          beats_seen = 0;
    int          sts_seen   = 0;
    bit          r_taken    = 1'b0;

    function automatic logic [63:0] pat(input logic [31:0] a);
        return {a ^ 32'hA5A5_0000, ~a};
    endfunction

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor on the falling edge, slave response driven just after the rising edge.
    initial begin : slave_monitor
        bit          active = 1'b0;
        logic [31:0] baddr = '0;
        logic [31:0] beat_addr;
        int          blen = 0;
        int          bidx = 0;
        bit          ar_wait = 1'b0;
        logic [39:0] ar_prev = '0;
        logic [64:0] e;
        logic [39:0] ea;
        forever begin
            @(negedge clk);
            if (rst) begin
                r_taken = 1'b0;
                ar_wait = 1'b0;
            end else begin
                r_taken = M_AXI_RVALID && M_AXI_RREADY;
                if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                    beats_seen++;
                    if (exp_beats.size() == 0) begin
                        chk("unexpected_beat", 72'(M_AXIS_TDATA), 72'h0);
                    end else begin
                        e = exp_beats.pop_front();
                        chk("tdata", 72'(M_AXIS_TDATA), 72'(e[63:0]));
                        chk("tlast", 72'(M_AXIS_TLAST), 72'(e[64]));
                        chk("tkeep", 72'(M_AXIS_TKEEP), 72'hff);
                    end
                end
                if (ar_wait) begin
                    chk("ar_stable", 72'({M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_ARLEN}),
                        72'({1'b1, ar_prev}));
                end
                ar_wait = M_AXI_ARVALID && !M_AXI_ARREADY;
                ar_prev = {M_AXI_ARADDR, M_AXI_ARLEN};
                if (M_AXI_ARVALID && M_AXI_ARREADY) begin
                    if (exp_ar.size() == 0) begin
                        chk("unexpected_ar", 72'({M_AXI_ARADDR, M_AXI_ARLEN}), 72'h0);
                    end else begin
                        ea = exp_ar.pop_front();
                        chk("ar_addr_len", 72'({M_AXI_ARADDR, M_AXI_ARLEN}), 72'(ea));
                        chk("ar_attr", 72'({M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARCACHE, M_AXI_ARPROT}),
                            72'({3'b011, 2'b01, 4'b0011, 3'b010}));
                    end
                    slv_ar.push_back({M_AXI_ARADDR, M_AXI_ARLEN});
                end
                if (M_AXIS_STS_TVALID && M_AXIS_STS_TREADY) begin
                    sts_seen++;
                    if (exp_sts.size() == 0) begin
                        chk("unexpected_sts", 72'(M_AXIS_STS_TDATA), 72'h0);
                    end else begin
                        chk("sts", 72'(M_AXIS_STS_TDATA), 72'(exp_sts.pop_front()));
                    end
                end
                if (busy) begin
                    chk("cmd_ready_busy", 72'(S_AXIS_CMD_TREADY), 72'h0);
                end
            end

            @(posedge clk);
            #1;
            if (rst) begin
                active       = 1'b0;
                slv_ar.delete();
                M_AXI_RVALID = 1'b0;
                M_AXI_RLAST  = 1'b0;
            end else begin
                if (active && r_taken) begin
                    bidx++;
                    if (bidx > blen) active = 1'b0;
                end
                if (!active && slv_ar.size() > 0) begin
                    ea     = slv_ar.pop_front();
                    baddr  = ea[39:8];
                    blen   = int'(ea[7:0]);
                    bidx   = 0;
                    active = 1'b1;
                end
                if (active) begin
                    beat_addr    = baddr + 32'(bidx * 8);
                    M_AXI_RVALID = 1'b1;
                    M_AXI_RDATA  = pat(beat_addr);
                    M_AXI_RLAST  = (bidx == blen);
                    M_AXI_RRESP  = (beat_addr == err_addr) ? err_resp : 2'b00;
                end else begin
                    M_AXI_RVALID = 1'b0;
                    M_AXI_RLAST  = 1'b0;
                end
            end
            M_AXI_ARREADY = 1'($urandom_range(0, 1));
            M_AXIS_TREADY = rand_tready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic send_cmd(input logic [22:0] btt, input logic [31:0] saddr,
                            input logic [3:0] tag, input logic eof);
        int          nb;
        int          rem;
        int          n;
        int          pg;
        logic [31:0] a;
        bit          slv;
        bit          dec;
        bit          accepted;
        slv = 1'b0;
        dec = 1'b0;
        if (btt == 0 || btt[2:0] != 0 || saddr[2:0] != 0) begin
            exp_sts.push_back({4'b0001, tag});
        end else begin
            nb = int'(btt) / 8;
            for (int i = 0; i < nb; i++) begin
                a = saddr + 32'(i * 8);
                exp_beats.push_back({eof && (i == nb - 1), pat(a)});
                if (a == err_addr && err_resp == 2'b10) slv = 1'b1;
                if (a == err_addr && err_resp == 2'b11) dec = 1'b1;
            end
            rem = nb;
            a   = saddr;
            while (rem > 0) begin
                n  = (rem < 16) ? rem : 16;
                pg = (4096 - int'(a[11:0])) / 8;
                if (pg < n) n = pg;
                exp_ar.push_back({a, 8'(n - 1)});
                a   = a + 32'(n * 8);
                rem = rem - n;
            end
            exp_sts.push_back({!(slv || dec), slv, dec, 1'b0, tag});
        end
        S_AXIS_CMD_TDATA  = {4'hA, tag, saddr, 1'b1, eof, 7'h55, btt};
        S_AXIS_CMD_TVALID = 1'b1;
        accepted = 1'b0;
        for (int c = 0; c < 50 && !accepted; c++) begin
            @(negedge clk);
            accepted = S_AXIS_CMD_TREADY;
            @(posedge clk);
            #1;
        end
        S_AXIS_CMD_TVALID = 1'b0;
        if (!accepted) chk("cmd_accept", 72'h0, 72'h1);
    endtask

    task automatic wait_idle(input string tag);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(negedge clk);
            done = (exp_sts.size() == 0) && (exp_beats.size() == 0) && !busy;
        end
        chk(tag, 72'({16'(exp_sts.size()), 16'(exp_beats.size()), 16'(exp_ar.size()), busy}), 72'h0);
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int  base;
        bit  seen;
        // reset state
        repeat (3) @(negedge clk);
        chk("rst_outputs", 72'({S_AXIS_CMD_TREADY, M_AXI_ARVALID, M_AXI_RREADY, M_AXIS_TVALID,
                               M_AXIS_STS_TVALID, busy}), 72'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_ready", 72'({S_AXIS_CMD_TREADY, busy}), 72'h2);
        @(posedge clk);
        #1;

        // single burst with EOF: status 0x85
        send_cmd(23'd64, 32'h1000_0000, 4'd5, 1'b1);
        wait_idle("drain_basic");

        // crosses a 4 KB boundary: two full bursts
        send_cmd(23'd256, 32'h1000_0F80, 4'd1, 1'b0);
        wait_idle("drain_4k");

        // boundary closer than the burst cap: 4 + 4 beats
        send_cmd(23'd64, 32'h2000_0FE0, 4'd8, 1'b1);
        wait_idle("drain_4k_short");

        // malformed commands: no AXI traffic, INTERR
        send_cmd(23'h2C, 32'h1000_0000, 4'd3, 1'b1);
        wait_idle("drain_interr_btt");
        send_cmd(23'd0, 32'h1000_0000, 4'hC, 1'b0);
        wait_idle("drain_interr_zero");
        send_cmd(23'd64, 32'h1000_0004, 4'd1, 1'b1);
        wait_idle("drain_interr_addr");

        // SLVERR on beat 3, then DECERR on a later beat
        err_addr = 32'h1000_0018;
        err_resp = 2'b10;
        send_cmd(23'd64, 32'h1000_0000, 4'd2, 1'b1);
        wait_idle("drain_slverr");
        err_addr = 32'h4000_0030;
        err_resp = 2'b11;
        send_cmd(23'd128, 32'h4000_0000, 4'd6, 1'b1);
        wait_idle("drain_decerr");
        err_addr = 32'hFFFF_FFFF;
        err_resp = 2'b00;

        // random stream backpressure with a held status
        rand_tready       = 1'b1;
        M_AXIS_STS_TREADY = 1'b0;
        send_cmd(23'd200, 32'h5000_0F00, 4'd9, 1'b1);
        seen = 1'b0;
        for (int c = 0; c < 3000 && !seen; c++) begin
            @(negedge clk);
            seen = M_AXIS_STS_TVALID;
        end
        for (int c = 0; c < 10; c++) begin
            chk("sts_hold", 72'({M_AXIS_STS_TVALID, S_AXIS_CMD_TREADY, M_AXIS_STS_TDATA}),
                72'({1'b1, 1'b0, 8'h89}));
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        M_AXIS_STS_TREADY = 1'b1;
        wait_idle("drain_backpressure");
        rand_tready = 1'b0;

        // reset in the middle of a data burst
        send_cmd(23'd128, 32'h3000_0000, 4'd7, 1'b1);
        base = beats_seen;
        for (int c = 0; c < 500 && beats_seen < base + 3; c++) @(negedge clk);
        chk("mid_beats", 72'(beats_seen >= base + 3), 72'h1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_async", 72'({S_AXIS_CMD_TREADY, M_AXI_ARVALID, M_AXI_RREADY, M_AXIS_TVALID,
                             M_AXIS_STS_TVALID, busy}), 72'h0);
        exp_beats.delete();
        exp_sts.delete();
        exp_ar.delete();
        base = sts_seen;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", 72'({S_AXIS_CMD_TREADY, busy, M_AXIS_STS_TVALID}), 72'h4);
        chk("post_rst_no_sts", 72'(sts_seen - base), 72'h0);
        @(posedge clk);
        #1;
        send_cmd(23'd64, 32'h3000_0100, 4'hA, 1'b1);
        wait_idle("drain_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
